// File: rtl/pkg_read_controller.sv
// pkg_read_controller: walks a packet's page chain, streams its words out and frees each page
module pkg_read_controller #(
    parameter int ADDR_PAGE_NUM_LOG = 4,
    parameter int PAGE_WORD_LOG     = 2,
    parameter int DATA_WIDTH        = 8,
    parameter int LEN_WIDTH         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pkg_read_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0]         pkg_read_head,
    input  logic [LEN_WIDTH-1:0]                 pkg_read_page_num,
    output logic                                 pkg_read_busy,
    output logic                                 pkg_read_done,
    output logic [ADDR_PAGE_NUM_LOG-1:0]         link_read_addr,
    input  logic [ADDR_PAGE_NUM_LOG-1:0]         link_read_data,
    output logic                                 ram_read_en,
    output logic [ADDR_PAGE_NUM_LOG+PAGE_WORD_LOG-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0]                ram_read_data,
    output logic                                 dout_valid,
    input  logic                                 dout_ready,
    output logic [DATA_WIDTH-1:0]                dout_data,
    output logic                                 empty_table_write_req,
    output logic [ADDR_PAGE_NUM_LOG-1:0]         empty_table_write_addr
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_PAGE_NUM_LOG-1:0] cur_page, next_page;
    logic [LEN_WIDTH-1:0] pages_left;
    logic [PAGE_WORD_LOG-1:0] word_cnt;
    logic in_flight, link_pend, issue, last;
    // one read at a time, and only when the output register is free or emptying this cycle
    assign issue = state == READ && !in_flight && (!dout_valid || dout_ready);
    assign last = issue && &word_cnt;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (pkg_read_req) state_nx = pkg_read_page_num == '0 ? DONE : READ;
            READ:  if (last && pages_left == LEN_WIDTH'(1)) state_nx = DRAIN;
            DRAIN: if (!in_flight && !dout_valid) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end
    // outputs; addresses are forced to zero whenever their strobe is idle
    always_comb begin
        pkg_read_busy = state == READ || state == DRAIN;
        pkg_read_done = state == DONE;
        ram_read_en = issue;
        ram_read_addr = issue ? {cur_page, word_cnt} : '0;
        link_read_addr = issue && word_cnt == '0 ? cur_page : '0;
        empty_table_write_req = last;
        empty_table_write_addr = last ? cur_page : '0;
    end
    // page walk, link capture and output register; the page is freed in its last-word issue cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_page <= '0;
            next_page <= '0;
            pages_left <= '0;
            word_cnt <= '0;
            in_flight <= 1'b0;
            link_pend <= 1'b0;
            dout_valid <= 1'b0;
            dout_data <= '0;
        end else begin
            in_flight <= issue;
            link_pend <= issue && word_cnt == '0;
            if (link_pend) next_page <= link_read_data;
            if (in_flight) begin
                dout_valid <= 1'b1;
                dout_data <= ram_read_data;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (state == IDLE && pkg_read_req) begin
                cur_page <= pkg_read_head;
                pages_left <= pkg_read_page_num;
                word_cnt <= '0;
            end else if (issue) begin
                word_cnt <= word_cnt + 1'b1;
                if (&word_cnt) begin
                    cur_page <= next_page;
                    pages_left <= pages_left - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/pkg_read_controller.md
Name: pkg_read_controller

Overview:
Read-side controller for the linked-list packet memory. It takes a queued packet's head page and page count, then walks the link table page by page. It streams every data word out through a valid/ready interface. As each page is consumed, it returns that page to the empty table through the empty-table write port (write_req/write_addr). It sits between the packet queue logic and the data/link RAMs, and is the consumer counterpart of the page-allocation path.

Parameters:
ADDR_PAGE_NUM_LOG, 4, page address width (number of pages = 2^ADDR_PAGE_NUM_LOG)
PAGE_WORD_LOG, 2, log2 of words per page; must be >= 1
DATA_WIDTH, 8, data word width
LEN_WIDTH, 8, width of the packet page count

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  asynchronous reset, active-high
pkg_read_req  in  1  start pulse; sampled only in IDLE
pkg_read_head  in  ADDR_PAGE_NUM_LOG  first page of the packet
pkg_read_page_num  in  LEN_WIDTH  number of pages in the packet
pkg_read_busy  out  1  high from the cycle after acceptance until done
pkg_read_done  out  1  one-cycle pulse when the packet is fully output
link_read_addr  out  ADDR_PAGE_NUM_LOG  link RAM address, = current page
link_read_data  in  ADDR_PAGE_NUM_LOG  next-page pointer; valid 1 cycle after the address
ram_read_en  out  1  data RAM read strobe
ram_read_addr  out  ADDR_PAGE_NUM_LOG+PAGE_WORD_LOG  {page, word offset}
ram_read_data  in  DATA_WIDTH  data word; valid 1 cycle after ram_read_en
dout_valid  out  1  output word valid
dout_ready  in  1  downstream accept
dout_data  out  DATA_WIDTH  output word
empty_table_write_req  out  1  one-cycle pulse returning a page
empty_table_write_addr  out  ADDR_PAGE_NUM_LOG  page being returned

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - All outputs are 0: busy, done, ram_read_en, dout_valid, empty_table_write_req, and all address/data outputs.
  - Reset mid-packet abandons the packet. Unreturned pages are not freed (intentional leak; the system re-initialises the empty table on reset).
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - pkg_read_req=1 with page_num>0: load cur_page=head, pages_left=page_num, word_cnt=0; go to READ.
  - pkg_read_req=1 with page_num=0: go straight to DONE; no RAM reads, no frees.
- READ, issue rule:
  - A read issues in a cycle only if no read is in flight and (dout_valid=0, or dout_valid&dout_ready in that cycle).
  - Issue: ram_read_en=1, ram_read_addr={cur_page, word_cnt}, word_cnt++.
  - Maximum throughput is 1 word per 2 cycles.
- Returned data:
  - The cycle after an issue, ram_read_data loads dout_data and dout_valid=1.
  - dout_data/dout_valid hold stable until dout_ready.
- Link fetch:
  - On the issue of word_cnt=0, link_read_addr=cur_page.
  - The next cycle, link_read_data is captured into next_page.
  - PAGE_WORD_LOG>=1 guarantees the capture precedes the last-word issue.
- Page retire, on issue of the last word (word_cnt = 2^PAGE_WORD_LOG-1), in that same cycle:
  - empty_table_write_req=1 and empty_table_write_addr=cur_page.
  - cur_page<=next_page, word_cnt<=0, pages_left--.
  - Freeing in the issue cycle is safe because the registered RAM has already sampled the address.
- Last page: if pages_left becomes 0, go to DRAIN. next_page is not used.
- DRAIN: wait until no read is in flight and dout_valid=0 (last word accepted), then go to DONE.
- DONE: pkg_read_done=1 for one cycle, then IDLE. busy=0 in that cycle.
- pkg_read_req while not in IDLE is ignored, with no side effects.
- Page counter arithmetic is unsigned. The link pointer is not checked; a chain of pages_left length is trusted.

Test Plan:
- Single page: head=3, page_num=1, dout_ready=1, RAM word = address.
  - ram_read_addr 12,13,14,15 on alternate cycles.
  - dout_data 12..15 in order.
  - One free pulse, addr=3, on the cycle addr 15 issues.
  - done pulses after word 15 is accepted; busy then 0.
- Three-page chain 5->9->2 (link RAM preset), page_num=3.
  - Reads cover pages 5, 9, 2 (addrs 20-23, 36-39, 8-11).
  - Frees 5, 9, 2 in order, each on its page's last-word issue.
  - 12 words out, then done.
- Backpressure: single page 7.
  - Hold dout_ready=0 for 5 cycles after the first valid: dout_data=28 stays stable and no further ram_read_en fires.
  - After release, remaining words 29-31 arrive in order with none lost or duplicated.
- Zero length: req with page_num=0.
  - Next cycle done=1.
  - ram_read_en and empty_table_write_req never asserted.
- req pulsed during READ with another head: ignored; the current packet completes unchanged.
- Reset mid-packet: assert rst during page 2 of a 3-page packet.
  - All outputs go 0 immediately.
  - No further frees occur.
  - A new req after reset runs normally from its own head.
